fpu_issue_scheduler: RTL

- Sequences FP operations between the FP decode/register stage and the FP execution units.
- Tracks FP register hazards with a 32-entry scoreboard and dispatches to a fixed-latency pipelined unit (fma/mac) or the iterative unit (fdiv/fsqrt).
- Owns the single FP register writeback port: completes single-cycle ops, reserves pipelined slots and buffers the iterative result.
- Drives writeback address, data and fflags into the FP register file and CSR.

---
 rtl/fpu_issue_scheduler.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fpu_issue_scheduler.sv
// FP issue scheduler: 32-entry register scoreboard, pipelined/iterative dispatch, single writeback port.
// Optional macro FPU_SCHED_PERF_EN adds the perf_issue_cnt / perf_stall_cnt counters.
module fpu_issue_scheduler #(
    parameter int PIPE_LAT = 3
) (
`ifdef FPU_SCHED_PERF_EN
    output logic [31:0] perf_issue_cnt,
    output logic [31:0] perf_stall_cnt,
`endif
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [1:0]  issue_class,
    input  logic        issue_fwren,
    input  logic [4:0]  issue_waddr,
    input  logic [2:0]  issue_frden,
    input  logic [4:0]  issue_raddr1,
    input  logic [4:0]  issue_raddr2,
    input  logic [4:0]  issue_raddr3,
    input  logic [31:0] single_result,
    input  logic [4:0]  single_flags,
    output logic        pipe_start,
    input  logic [31:0] pipe_result,
    input  logic [4:0]  pipe_flags,
    output logic        iter_start,
    input  logic        iter_done,
    input  logic [31:0] iter_result,
    input  logic [4:0]  iter_flags,
    input  logic        flush,
    output logic        iter_kill,
    output logic        wb_valid,
    output logic [4:0]  wb_waddr,
    output logic [31:0] wb_wdata,
    output logic [4:0]  wb_fflags
);
    localparam logic [1:0] CLS_SINGLE = 2'd0;
    localparam logic [1:0] CLS_PIPE   = 2'd1;
    localparam logic [1:0] CLS_ITER   = 2'd2;

    logic [31:0]       busy;
    logic [31:0]       busy_nxt;
    logic [PIPE_LAT:1] pv_valid;
    logic [PIPE_LAT:1] pv_fwren;
    logic [4:0]        pv_waddr [1:PIPE_LAT];
    logic              iter_busy;
    logic              iter_fwren;
    logic [4:0]        iter_waddr;
    logic              buf_valid;
    logic              buf_fwren;
    logic [4:0]        buf_waddr;
    logic [4:0]        buf_flags;
    logic [31:0]       buf_data;
    logic              hazard;
    logic              unit_free;
    logic              accept;
    logic              single_acc;

    always_comb begin
        hazard = (issue_frden[0] & busy[issue_raddr1])
               | (issue_frden[1] & busy[issue_raddr2])
               | (issue_frden[2] & busy[issue_raddr3])
               | (issue_fwren & busy[issue_waddr]);
        unit_free = 1'b0;
        case (issue_class)
            // a single-cycle op would collide with the pipe result on the wb port
            CLS_SINGLE: unit_free = ~pv_valid[PIPE_LAT];
            CLS_PIPE:   unit_free = 1'b1;
            CLS_ITER:   unit_free = ~iter_busy & ~buf_valid;
            default:    unit_free = 1'b0;
        endcase
    end

    assign issue_ready = ~reset & ~flush & ~hazard & unit_free;
    assign accept      = issue_valid & issue_ready;
    assign single_acc  = accept & (issue_class == CLS_SINGLE);
    assign pipe_start  = accept & (issue_class == CLS_PIPE);
    assign iter_start  = accept & (issue_class == CLS_ITER);
    assign iter_kill   = flush & (iter_busy | buf_valid);

    always_comb begin
        busy_nxt = busy;
        if (wb_valid) busy_nxt[wb_waddr] = 1'b0;
        if (accept & issue_fwren) busy_nxt[issue_waddr] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            busy      <= '0;
            pv_valid  <= '0;
            iter_busy <= 1'b0;
            buf_valid <= 1'b0;
            wb_valid  <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
            wb_fflags <= '0;
        end else begin
            busy     <= busy_nxt;
            pv_valid <= {pv_valid[PIPE_LAT-1:1], pipe_start};

            if (iter_start) iter_busy <= 1'b1;
            else if (iter_done) iter_busy <= 1'b0;

            wb_valid  <= 1'b0;
            wb_waddr  <= '0;
            wb_wdata  <= '0;
            wb_fflags <= '0;
            if (pv_valid[PIPE_LAT]) begin
                wb_valid  <= pv_fwren[PIPE_LAT];
                wb_waddr  <= pv_fwren[PIPE_LAT] ? pv_waddr[PIPE_LAT] : 5'd0;
                wb_wdata  <= pv_fwren[PIPE_LAT] ? pipe_result : 32'd0;
                wb_fflags <= pipe_flags;
            end else if (single_acc) begin
                wb_valid  <= issue_fwren;
                wb_waddr  <= issue_fwren ? issue_waddr : 5'd0;
                wb_wdata  <= issue_fwren ? single_result : 32'd0;
                wb_fflags <= single_flags;
            end else if (buf_valid) begin
                wb_valid  <= buf_fwren;
                wb_waddr  <= buf_fwren ? buf_waddr : 5'd0;
                wb_wdata  <= buf_fwren ? buf_data : 32'd0;
                wb_fflags <= buf_flags;
                buf_valid <= 1'b0;
            end

            // buffer is always empty while the iterative unit is busy
            if (iter_busy && iter_done) buf_valid <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        pv_fwren    <= {pv_fwren[PIPE_LAT-1:1], issue_fwren};
        pv_waddr[1] <= issue_waddr;
        for (int k = PIPE_LAT; k > 1; k--) pv_waddr[k] <= pv_waddr[k-1];
        if (iter_start) begin
            iter_fwren <= issue_fwren;
            iter_waddr <= issue_waddr;
        end
        if (iter_busy && iter_done) begin
            buf_fwren <= iter_fwren;
            buf_waddr <= iter_waddr;
            buf_data  <= iter_result;
            buf_flags <= iter_flags;
        end
    end

`ifdef FPU_SCHED_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_issue_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept) perf_issue_cnt <= perf_issue_cnt + 32'd1;
            if (issue_valid && !issue_ready && !flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
